// File: rtl/ram_neighborhood_reader.sv
// Fetches the 2x2 pixel neighbourhood around (x,y) from a pipelined read port
// and presents all four pixels at once over a valid/ready handshake.
module ram_neighborhood_reader #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int IMG_WIDTH   = 256,
  parameter int IMG_HEIGHT  = 256,
  parameter int COORD_WIDTH = 8,
  parameter int RD_LATENCY  = 2
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [COORD_WIDTH-1:0] req_x,
  input  logic [COORD_WIDTH-1:0] req_y,
  output logic [ADDR_WIDTH-1:0]  rdaddress,
  input  logic [DATA_WIDTH-1:0]  q,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  p00,
  output logic [DATA_WIDTH-1:0]  p01,
  output logic [DATA_WIDTH-1:0]  p10,
  output logic [DATA_WIDTH-1:0]  p11,
  output logic                   busy
);

  localparam int unsigned IMG_W_U = IMG_WIDTH;
  localparam int unsigned IMG_H_U = IMG_HEIGHT;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

  state_t                               state_q, state_d;
  logic [1:0]                           cnt_q, cnt_d;
  logic [COORD_WIDTH-1:0]               x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
  logic [ADDR_WIDTH-1:0]                rdaddress_q, rdaddress_d;
  logic [RD_LATENCY-1:0]                tvld_q, tvld_d;
  logic [RD_LATENCY-1:0][1:0]           ttag_q, ttag_d;
  logic [3:0][DATA_WIDTH-1:0]           p_q, p_d;
  logic                                 acc, cap_last;
  logic [COORD_WIDTH-1:0]               xc, xn, yc, yn;

  function automatic logic [COORD_WIDTH-1:0] clamp(input logic [COORD_WIDTH-1:0] v,
                                                   input int unsigned lim);
    if (32'(v) >= lim) return COORD_WIDTH'(lim - 32'd1);
    else               return v;
  endfunction

  function automatic logic [COORD_WIDTH-1:0] inc_clamp(input logic [COORD_WIDTH-1:0] v,
                                                       input int unsigned lim);
    if (32'(v) + 32'd1 >= lim) return COORD_WIDTH'(lim - 32'd1);
    else                       return v + 1'b1;
  endfunction

  // Linear address at full width, then cut down to the RAM address width.
  function automatic logic [ADDR_WIDTH-1:0] pix_addr(input logic [COORD_WIDTH-1:0] x,
                                                     input logic [COORD_WIDTH-1:0] y);
    logic [31:0] full;
    full = 32'(y) * IMG_W_U + 32'(x);
    return full[ADDR_WIDTH-1:0];
  endfunction

  assign xc       = clamp(req_x, IMG_W_U);
  assign yc       = clamp(req_y, IMG_H_U);
  assign xn       = inc_clamp(xc, IMG_W_U);
  assign yn       = inc_clamp(yc, IMG_H_U);
  assign acc      = req_valid && req_ready;
  assign cap_last = tvld_q[RD_LATENCY-1] && (ttag_q[RD_LATENCY-1] == 2'd3);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc)            state_d = ISSUE;
      ISSUE:   if (cnt_q == 2'd3)  state_d = DRAIN;
      DRAIN:   if (cap_last)       state_d = OUT;
      OUT:     if (out_ready)      state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = rst_n && (state_q == IDLE);
    out_valid = (state_q == OUT);
    busy      = (state_q != IDLE);
  end

  always_comb begin
    cnt_d       = cnt_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    y0_d        = y0_q;
    y1_d        = y1_q;
    rdaddress_d = rdaddress_q;
    p_d         = p_q;
    // Tag stage 0 follows the address currently on rdaddress.
    tvld_d[0]   = (state_q == ISSUE);
    ttag_d[0]   = cnt_q;
    for (int j = RD_LATENCY - 1; j > 0; j--) begin
      tvld_d[j] = tvld_q[j-1];
      ttag_d[j] = ttag_q[j-1];
    end
    if (acc) begin
      x0_d        = xc;
      x1_d        = xn;
      y0_d        = yc;
      y1_d        = yn;
      cnt_d       = 2'd0;
      rdaddress_d = pix_addr(xc, yc);
    end else if ((state_q == ISSUE) && (cnt_q != 2'd3)) begin
      cnt_d = cnt_q + 2'd1;
      case (cnt_q)
        2'd0:    rdaddress_d = pix_addr(x1_q, y0_q);
        2'd1:    rdaddress_d = pix_addr(x0_q, y1_q);
        default: rdaddress_d = pix_addr(x1_q, y1_q);
      endcase
    end
    if (tvld_q[RD_LATENCY-1]) p_d[ttag_q[RD_LATENCY-1]] = q;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      x0_q        <= '0;
      x1_q        <= '0;
      y0_q        <= '0;
      y1_q        <= '0;
      rdaddress_q <= '0;
      tvld_q      <= '0;
      ttag_q      <= '0;
      p_q         <= '0;
    end else begin
      cnt_q       <= cnt_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      y0_q        <= y0_d;
      y1_q        <= y1_d;
      rdaddress_q <= rdaddress_d;
      tvld_q      <= tvld_d;
      ttag_q      <= ttag_d;
      p_q         <= p_d;
    end
  end

  assign rdaddress = rdaddress_q;
  assign p00       = p_q[0];
  assign p01       = p_q[1];
  assign p10       = p_q[2];
  assign p11       = p_q[3];

endmodule

// File: tb/tb_ram_neighborhood_reader.sv
// Directed bench for ram_neighborhood_reader on a 16x16 image with a
// two-cycle RAM whose contents equal the low address byte.
module tb_ram_neighborhood_reader;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_x, req_y;
  logic [15:0] rdaddress;
  logic [7:0]  q;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  p00, p01, p10, p11;
  logic        busy;
  logic [15:0] ram_a_q;

  int n_tests = 0;
  int n_fail  = 0;

  ram_neighborhood_reader #(
    .ADDR_WIDTH(16), .DATA_WIDTH(8), .IMG_WIDTH(16), .IMG_HEIGHT(16),
    .COORD_WIDTH(8), .RD_LATENCY(2)
  ) dut (
    .clock(clock), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .rdaddress(rdaddress), .q(q),
    .out_valid(out_valid), .out_ready(out_ready),
    .p00(p00), .p01(p01), .p10(p10), .p11(p11), .busy(busy)
  );

  always #5 clock = ~clock;

  // Two-stage read port: address register, then data register; mem[a] = a[7:0].
  always @(posedge clock) begin
    ram_a_q <= rdaddress;
    q       <= ram_a_q[7:0];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at the negedge just after the acceptance edge.
  task automatic collect(input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3);
    int cyc;
    logic [15:0] a [4];
    cyc = 0;
    for (int i = 0; i < 4; i++) a[i] = 16'hxxxx;
    while (!out_valid && cyc < 20) begin
      if (cyc < 4) a[cyc] = rdaddress;
      @(negedge clock);
      cyc++;
    end
    chk("latency", cyc, 6);
    chk("addr0", {16'h0, a[0]}, {24'h0, e0});
    chk("addr1", {16'h0, a[1]}, {24'h0, e1});
    chk("addr2", {16'h0, a[2]}, {24'h0, e2});
    chk("addr3", {16'h0, a[3]}, {24'h0, e3});
    chk("pix", {p00, p01, p10, p11}, {e0, e1, e2, e3});
    chk("busy_out", busy, 1);
    chk("rdy_out", req_ready, 0);
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] e0, input logic [7:0] e1,
                      input logic [7:0] e2, input logic [7:0] e3);
    req_valid = 1'b1;
    req_x     = x;
    req_y     = y;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    collect(e0, e1, e2, e3);
  endtask

  // Called with out_valid=1 and out_ready=1; checks the cycle after the transfer.
  task automatic after_xfer();
    @(negedge clock);
    chk("xfer_vld", out_valid, 0);
    chk("xfer_rdy", req_ready, 1);
    chk("xfer_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst_n = 1'b0; req_valid = 1'b0; req_x = '0; req_y = '0; out_ready = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_rdy", req_ready, 0);
    chk("rst_vld", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", rdaddress, 0);
    chk("rst_pix", {p00, p01, p10, p11}, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_rdy", req_ready, 1);
    @(negedge clock);

    send(8'd3, 8'd2, 8'h23, 8'h24, 8'h33, 8'h34);
    after_xfer();
    send(8'd15, 8'd4, 8'h4F, 8'h4F, 8'h5F, 8'h5F);
    after_xfer();
    send(8'd15, 8'd15, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    after_xfer();
    send(8'd20, 8'd30, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    after_xfer();

    out_ready = 1'b0;
    send(8'd0, 8'd0, 8'h00, 8'h01, 8'h10, 8'h11);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("bp_vld", out_valid, 1);
      chk("bp_pix", {p00, p01, p10, p11}, 32'h0001_1011);
      chk("bp_rdy", req_ready, 0);
      chk("bp_busy", busy, 1);
    end
    out_ready = 1'b1;
    after_xfer();
    @(negedge clock);
    chk("bp_once", out_valid, 0);

    // Back-to-back: req_valid stays high; the second coordinate waits out the first.
    req_valid = 1'b1; req_x = 8'd1; req_y = 8'd1;
    @(posedge clock);
    @(negedge clock);
    req_x = 8'd2; req_y = 8'd2;
    collect(8'h11, 8'h12, 8'h21, 8'h22);
    @(negedge clock);
    chk("b2b_vld", out_valid, 0);
    chk("b2b_rdy", req_ready, 1);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    chk("b2b_busy", busy, 1);
    collect(8'h22, 8'h23, 8'h32, 8'h33);
    after_xfer();

    // Reset while the (5,5) request is still issuing.
    req_valid = 1'b1; req_x = 8'd5; req_y = 8'd5;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    chk("mid_addr0", rdaddress, 16'h0055);
    @(negedge clock);
    rst_n = 1'b0;
    #1;
    chk("mid_addr", rdaddress, 0);
    chk("mid_pix", {p00, p01, p10, p11}, 0);
    chk("mid_busy", busy, 0);
    chk("mid_rdy", req_ready, 0);
    @(negedge clock);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (out_valid) seen++;
    end
    chk("mid_novld", seen, 0);
    send(8'd6, 8'd6, 8'h66, 8'h67, 8'h76, 8'h77);
    after_xfer();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
